feature_reader: RTL and testbench
=================================

FEATURE_READER -- requirements
Module: feature_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one feature word in the feature BRAM.
REQ-002 Parameter NUM_FEATURE_OUT, default 7: number of features per node.
REQ-003 Parameter NUM_SUBGRAPHS, default 2708: number of nodes to read.
REQ-004 Parameter RD_LATENCY, default 2: feature BRAM read latency in cycles; legal values are 1 and 2.
REQ-005 Derived constants: NEW_FEATURE_DEPTH = NUM_SUBGRAPHS*NUM_FEATURE_OUT; NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH); FIFO_DEPTH = RD_LATENCY+2.
REQ-006 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port start_i, input, 1: one-cycle start pulse, driven by gat_ready.
REQ-009 Port busy_o, output, 1: high from the cycle after an accepted start until done_o.
REQ-010 Port done_o, output, 1: one-cycle pulse when readout is complete.
REQ-011 Port feat_bram_addrb, output, NEW_FEATURE_ADDR_W: feature BRAM port-B read address.
REQ-012 Port feat_bram_dout, input, DATA_WIDTH: feature BRAM read data, valid RD_LATENCY cycles after the address.
REQ-013 Port feat_vld_o, input/output role: output, 1: stream data valid.
REQ-014 Port feat_rdy_i, input, 1: stream sink ready.
REQ-015 Port feat_data_o, output, DATA_WIDTH: feature word.
REQ-016 Port feat_last_o, output, 1: marks the last feature of a node.
REQ-017 Port feat_node_o, output, $clog2(NUM_SUBGRAPHS): node index of the current word.
REQ-018 Port cls_vld_o, output, 1: one-cycle class-result pulse.
REQ-019 Port cls_idx_o, output, $clog2(NUM_FEATURE_OUT): argmax feature index.
REQ-020 Port cls_node_o, output, $clog2(NUM_SUBGRAPHS): node index of the class result.

Function
REQ-021 The FSM states are IDLE, READ, DRAIN and DONE.
- IDLE to READ on start_i.
- READ to DRAIN once address NEW_FEATURE_DEPTH-1 has been issued.
- DRAIN to DONE when the FIFO is empty, nothing is in flight and the last beat is accepted.
- DONE to IDLE after one cycle, with done_o=1 during DONE.
REQ-022 start_i is ignored in READ, DRAIN and DONE.
REQ-023 In READ, one read is issued per cycle only while (in-flight + FIFO occupancy) < FIFO_DEPTH.
- The address increments by 1 per issued read, from 0.
- The address never wraps or exceeds NEW_FEATURE_DEPTH-1.
REQ-024 Returned data enters the FIFO in address order, exactly RD_LATENCY cycles after issue, tracked by a valid shift register.
REQ-025 The FIFO never overflows, and data is never dropped or duplicated under any feat_rdy_i pattern.
REQ-026 Stream handshake:
- A beat transfers when feat_vld_o && feat_rdy_i.
- While feat_vld_o=1 and not accepted, feat_data_o, feat_last_o and feat_node_o hold stable.
- feat_vld_o does not depend combinationally on feat_rdy_i.
REQ-027 feat_last_o=1 exactly on beats whose feature index equals NUM_FEATURE_OUT-1.
REQ-028 feat_node_o increments after each last beat.
REQ-029 With feat_rdy_i held at 1, steady-state throughput is one beat per cycle.
- First-beat latency is at most RD_LATENCY+2 cycles after start_i.
REQ-030 Argmax is computed over accepted beats per node.
- Features are compared as two's-complement signed values.
- Ties resolve to the lowest index.
REQ-031 cls_vld_o pulses exactly one cycle after a node's last beat is accepted, with that node's cls_idx_o and cls_node_o.
- cls has no backpressure.
REQ-032 Outside the cls_vld_o pulse, cls_idx_o and cls_node_o hold their last values.

Reset
REQ-033 On rst=1 at a clock edge:
- State goes to IDLE and the FIFO and in-flight tracker are flushed.
- busy_o, done_o, feat_vld_o, feat_last_o, cls_vld_o = 0.
- feat_bram_addrb, feat_data_o, feat_node_o, cls_idx_o, cls_node_o = 0.
REQ-034 rst asserted mid-READ or mid-DRAIN aborts the readout without emitting done_o; a later start_i restarts from address 0.

Structure
REQ-035 The FSM state enum and the NEW_FEATURE_DEPTH and NEW_FEATURE_ADDR_W derivations live in the shared GAT package.
REQ-036 A sub-module feature_reader_fifo (synchronous FIFO, parameterised width and depth, with count output) holds the returned data.
- Argmax, FSM and address logic stay in feature_reader.

Verification
REQ-037 NUM_SUBGRAPHS=2, NUM_FEATURE_OUT=3, BRAM = {5,-2,9, -1,-1,-7}, feat_rdy_i=1.
- Required: six beats in order with last on beats 3 and 6, then cls (node0, idx2) and (node1, idx0), then a single done_o.
REQ-038 Same data, feat_rdy_i toggling 1,0,0,1 repeating.
- Required: identical beat sequence, data held stable while stalled, no loss.
REQ-039 feat_rdy_i=0 for 20 cycles after start.
- Required: at most FIFO_DEPTH reads issued and addrb stops advancing.
- After release, all 6 beats arrive intact.
REQ-040 rst asserted after 3 accepted beats.
- Required: all outputs 0 the next cycle and no done_o.
- A new start_i yields a full sequence beginning with address 0.
REQ-041 start_i pulsed again during READ.
- Required: ignored, exactly one done_o.
- RD_LATENCY=1 and RD_LATENCY=2 both pass REQ-037.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared GAT definitions: reader FSM states and
// feature BRAM geometry helpers.
package gat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } fr_state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int new_feature_depth(
    input int ns,
    input int nf
  );
    return ns * nf;
  endfunction

  function automatic int new_feature_addr_w(
    input int ns,
    input int nf
  );
    return clog2_min1(new_feature_depth(ns, nf));
  endfunction

endpackage

// File: rtl/feature_reader_fifo.sv
// Small synchronous FIFO with occupancy count,
// head word always visible on dout.
module feature_reader_fifo
  import gat_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/feature_reader.sv
// Streams node features out of the feature BRAM
// and reports the per-node signed argmax.
module feature_reader
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_FEATURE_OUT = 7,
  parameter int NUM_SUBGRAPHS   = 2708,
  parameter int RD_LATENCY      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic [new_feature_addr_w(NUM_SUBGRAPHS,
                NUM_FEATURE_OUT)-1:0] feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0] feat_bram_dout,
  output logic feat_vld_o,
  input  logic feat_rdy_i,
  output logic [DATA_WIDTH-1:0] feat_data_o,
  output logic feat_last_o,
  output logic [clog2_min1(NUM_SUBGRAPHS)-1:0] feat_node_o,
  output logic cls_vld_o,
  output logic [clog2_min1(NUM_FEATURE_OUT)-1:0] cls_idx_o,
  output logic [clog2_min1(NUM_SUBGRAPHS)-1:0] cls_node_o
);

  localparam int DEPTH =
    new_feature_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT);
  localparam int AW =
    new_feature_addr_w(NUM_SUBGRAPHS, NUM_FEATURE_OUT);
  localparam int NW = clog2_min1(NUM_SUBGRAPHS);
  localparam int FW = clog2_min1(NUM_FEATURE_OUT);
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(2 * FIFO_DEPTH + 1);

  fr_state_e             state;
  logic [AW-1:0]         addr_q;
  logic [RD_LATENCY-1:0] pend_q;
  logic [FCW-1:0]        fifo_cnt;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         occupancy;
  logic                  issue;
  logic                  push;
  logic                  fire;
  logic                  last_feat;
  logic                  last_node;
  logic                  beat_wins;
  logic [FW-1:0]         feat_idx;
  logic [NW-1:0]         out_node;
  logic signed [DATA_WIDTH-1:0] best_val;
  logic [FW-1:0]         best_idx;

  // Reads are throttled so everything in flight
  // is guaranteed a FIFO slot when it returns.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      in_flight = in_flight + CW'(pend_q[i]);
  end

  assign occupancy = in_flight + CW'(fifo_cnt);
  assign issue = (state == READ) &&
                 (occupancy < CW'(FIFO_DEPTH));
  assign push  = pend_q[RD_LATENCY-1];

  assign feat_bram_addrb = addr_q;
  assign feat_vld_o  = (fifo_cnt != '0);
  assign fire        = feat_vld_o && feat_rdy_i;
  assign last_feat   = feat_idx == FW'(NUM_FEATURE_OUT - 1);
  assign last_node   = out_node == NW'(NUM_SUBGRAPHS - 1);
  assign feat_last_o = feat_vld_o && last_feat;
  assign feat_node_o = out_node;
  assign beat_wins   = (feat_idx == '0) ||
                       ($signed(feat_data_o) > best_val);

  feature_reader_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (feat_bram_dout),
    .pop   (fire),
    .dout  (feat_data_o),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= (pend_q << 1) | RD_LATENCY'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      feat_idx   <= '0;
      out_node   <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      cls_vld_o  <= 1'b0;
      cls_idx_o  <= '0;
      cls_node_o <= '0;
    end else begin
      done_o    <= 1'b0;
      cls_vld_o <= 1'b0;
      if (fire) begin
        if (beat_wins) begin
          best_val <= $signed(feat_data_o);
          best_idx <= feat_idx;
        end
        if (last_feat) begin
          cls_vld_o  <= 1'b1;
          cls_idx_o  <= beat_wins ? feat_idx : best_idx;
          cls_node_o <= out_node;
          feat_idx   <= '0;
          out_node   <= last_node ? '0 : out_node + NW'(1);
        end else begin
          feat_idx <= feat_idx + FW'(1);
        end
      end
      unique case (state)
        IDLE: if (start_i) begin
          state    <= READ;
          addr_q   <= '0;
          busy_o   <= 1'b1;
          feat_idx <= '0;
          out_node <= '0;
        end
        READ: if (issue) begin
          if (addr_q == AW'(DEPTH - 1)) state <= DRAIN;
          else addr_q <= addr_q + AW'(1);
        end
        DRAIN: if (fire && last_feat && last_node) begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_reader.sv
// Bench for feature_reader: RD_LATENCY 1 and 2 run
// side by side against a queue-based reference.
module tb_feature_reader;

  localparam int DW    = 8;
  localparam int NF    = 3;
  localparam int NS    = 2;
  localparam int DEPTH = NS * NF;
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = $clog2(NS);
  localparam int FW    = $clog2(NF);
  localparam int BW    = NW + 1 + DW;
  localparam int CLW   = NW + FW;

  typedef logic [BW-1:0]  beat_t;
  typedef logic [CLW-1:0] cls_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, rdy;
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] addrb [2];
  logic [DW-1:0] dout [2];
  logic [DW-1:0] data [2];
  logic          busy [2], done [2], vld [2];
  logic          last [2], cvld [2];
  logic [NW-1:0] node [2], cnode [2];
  logic [FW-1:0] cidx [2];

  feature_reader #(
    .DATA_WIDTH(DW), .NUM_FEATURE_OUT(NF),
    .NUM_SUBGRAPHS(NS), .RD_LATENCY(1)
  ) dut_l1 (
    .clk(clk), .rst(rst), .start_i(start),
    .busy_o(busy[0]), .done_o(done[0]),
    .feat_bram_addrb(addrb[0]),
    .feat_bram_dout(dout[0]),
    .feat_vld_o(vld[0]), .feat_rdy_i(rdy),
    .feat_data_o(data[0]), .feat_last_o(last[0]),
    .feat_node_o(node[0]), .cls_vld_o(cvld[0]),
    .cls_idx_o(cidx[0]), .cls_node_o(cnode[0])
  );

  feature_reader #(
    .DATA_WIDTH(DW), .NUM_FEATURE_OUT(NF),
    .NUM_SUBGRAPHS(NS), .RD_LATENCY(2)
  ) dut_l2 (
    .clk(clk), .rst(rst), .start_i(start),
    .busy_o(busy[1]), .done_o(done[1]),
    .feat_bram_addrb(addrb[1]),
    .feat_bram_dout(dout[1]),
    .feat_vld_o(vld[1]), .feat_rdy_i(rdy),
    .feat_data_o(data[1]), .feat_last_o(last[1]),
    .feat_node_o(node[1]), .cls_vld_o(cvld[1]),
    .cls_idx_o(cidx[1]), .cls_node_o(cnode[1])
  );

  logic [DW-1:0] l1_q, l2_q0, l2_q1;
  always @(posedge clk) begin
    l1_q  <= mem[addrb[0]];
    l2_q0 <= mem[addrb[1]];
    l2_q1 <= l2_q0;
  end
  assign dout[0] = l1_q;
  assign dout[1] = l2_q1;

  beat_t beats [2][$];
  cls_t  clss  [2][$];
  int    done_cnt [2], stall_err [2];
  int    first_cyc [2], last_cyc [2];
  logic  hold [2];
  beat_t held [2];
  int    cyc = 0;
  logic  clr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        beats[d].delete();
        clss[d].delete();
        done_cnt[d]  = 0;
        stall_err[d] = 0;
        hold[d]      = 1'b0;
      end else if (rst) begin
        hold[d] = 1'b0;
      end else begin
        if (hold[d] && (!vld[d] ||
            {node[d], last[d], data[d]} !== held[d]))
          stall_err[d]++;
        if (vld[d] && rdy) begin
          if (beats[d].size() == 0) first_cyc[d] = cyc;
          last_cyc[d] = cyc;
          beats[d].push_back({node[d], last[d], data[d]});
        end
        if (cvld[d]) clss[d].push_back({cnode[d], cidx[d]});
        if (done[d]) done_cnt[d]++;
        hold[d] = vld[d] && !rdy;
        held[d] = {node[d], last[d], data[d]};
      end
    end
  end

  beat_t exp_beats [$];
  cls_t  exp_cls [$];
  int    checks = 0;
  int    errors = 0;
  int    start_cyc;
  int    snap_addr [2], snap_beats [2];
  logic  snap_busy [2];
  bit    finished;

  task automatic build_model();
    int best, bi, v;
    exp_beats.delete();
    exp_cls.delete();
    for (int n = 0; n < NS; n++) begin
      best = 0;
      bi   = 0;
      for (int f = 0; f < NF; f++) begin
        v = $signed(mem[n*NF+f]);
        if (f == 0 || v > best) begin
          best = v;
          bi   = f;
        end
        exp_beats.push_back({NW'(n), f == NF - 1,
                             mem[n*NF+f]});
      end
      exp_cls.push_back({NW'(n), FW'(bi)});
    end
  endtask

  task automatic load_directed();
    mem[0] = 8'h05; mem[1] = 8'hFE; mem[2] = 8'h09;
    mem[3] = 8'hFF; mem[4] = 8'hFF; mem[5] = 8'hF9;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic run(input int mode);
    int extra;
    extra    = 0;
    finished = 0;
    tick();
    for (int k = 0; k < 300; k++) begin
      case (mode)
        1: rdy = (k % 4 == 0) || (k % 4 == 3);
        2: rdy = 1'($urandom_range(0, 1));
        3: rdy = (k >= 20);
        default: rdy = 1'b1;
      endcase
      start = (k == 0) ||
              (mode == 4 && (k == 3 || k == 5));
      if (k == 0) start_cyc = cyc;
      if (k == 19) begin
        for (int d = 0; d < 2; d++) begin
          snap_addr[d]  = int'(addrb[d]);
          snap_beats[d] = beats[d].size();
          snap_busy[d]  = busy[d];
        end
      end
      if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
        extra++;
        if (extra > 6) begin
          finished = 1;
          break;
        end
      end
      tick();
    end
    start = 1'b0;
    rdy   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rdy = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], done[d], vld[d], last[d], cvld[d],
           addrb[d], data[d], node[d], cidx[d],
           cnode[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs lat%0d got %h want 0",
          d + 1, {busy[d], done[d], vld[d], last[d],
          cvld[d], addrb[d], data[d], node[d], cidx[d],
          cnode[d]});
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    load_directed();
    build_model();
    clear_mon();
    run(0);
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL stream_done got %0d/%0d want 1/1",
        done_cnt[0], done_cnt[1]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (beats[d].size() != DEPTH) begin
        errors++;
        $display("FAIL stream_beats lat%0d got %0d want %0d",
          d + 1, beats[d].size(), DEPTH);
      end
      for (int i = 0; i < DEPTH && i < beats[d].size(); i++) begin
        checks++;
        if (beats[d][i] !== exp_beats[i]) begin
          errors++;
          $display("FAIL stream_beat%0d lat%0d got %h want %h",
            i, d + 1, beats[d][i], exp_beats[i]);
        end
      end
      checks++;
      if (clss[d].size() != NS) begin
        errors++;
        $display("FAIL stream_cls_n lat%0d got %0d want %0d",
          d + 1, clss[d].size(), NS);
      end
      for (int i = 0; i < NS && i < clss[d].size(); i++) begin
        checks++;
        if (clss[d][i] !== exp_cls[i]) begin
          errors++;
          $display("FAIL stream_cls%0d lat%0d got %h want %h",
            i, d + 1, clss[d][i], exp_cls[i]);
        end
      end
      checks++;
      if (done_cnt[d] != 1) begin
        errors++;
        $display("FAIL stream_done_n lat%0d got %0d want 1",
          d + 1, done_cnt[d]);
      end
      checks++;
      if (first_cyc[d] - start_cyc > d + 3) begin
        errors++;
        $display("FAIL stream_latency lat%0d got %0d want <=%0d",
          d + 1, first_cyc[d] - start_cyc, d + 3);
      end
      checks++;
      if (last_cyc[d] - first_cyc[d] != DEPTH - 1) begin
        errors++;
        $display("FAIL stream_rate lat%0d got %0d want %0d",
          d + 1, last_cyc[d] - first_cyc[d], DEPTH - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    load_directed();
    build_model();
    clear_mon();
    run(1);
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL bp_done got %0d/%0d want 1/1",
        done_cnt[0], done_cnt[1]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (beats[d].size() != DEPTH) begin
        errors++;
        $display("FAIL bp_beats lat%0d got %0d want %0d",
          d + 1, beats[d].size(), DEPTH);
      end
      for (int i = 0; i < DEPTH && i < beats[d].size(); i++) begin
        checks++;
        if (beats[d][i] !== exp_beats[i]) begin
          errors++;
          $display("FAIL bp_beat%0d lat%0d got %h want %h",
            i, d + 1, beats[d][i], exp_beats[i]);
        end
      end
      for (int i = 0; i < NS; i++) begin
        checks++;
        if (i >= clss[d].size() || clss[d][i] !== exp_cls[i]) begin
          errors++;
          $display("FAIL bp_cls%0d lat%0d got %0d entries want %h",
            i, d + 1, clss[d].size(), exp_cls[i]);
        end
      end
      checks++;
      if (stall_err[d] != 0 || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL bp_stable lat%0d got %0d/%0d want 0/1",
          d + 1, stall_err[d], done_cnt[d]);
      end
    end
  endtask

  task automatic test_stall();
    int want;
    load_directed();
    build_model();
    clear_mon();
    run(3);
    for (int d = 0; d < 2; d++) begin
      want = (d + 3 < DEPTH - 1) ? d + 3 : DEPTH - 1;
      checks++;
      if (snap_addr[d] != want || snap_beats[d] != 0 ||
          snap_busy[d] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold lat%0d got %0d/%0d/%0b want %0d/0/1",
          d + 1, snap_addr[d], snap_beats[d], snap_busy[d], want);
      end
      checks++;
      if (beats[d].size() != DEPTH || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL stall_drain lat%0d got %0d/%0d want %0d/1",
          d + 1, beats[d].size(), done_cnt[d], DEPTH);
      end
      for (int i = 0; i < DEPTH && i < beats[d].size(); i++) begin
        checks++;
        if (beats[d][i] !== exp_beats[i]) begin
          errors++;
          $display("FAIL stall_beat%0d lat%0d got %h want %h",
            i, d + 1, beats[d][i], exp_beats[i]);
        end
      end
      checks++;
      if (stall_err[d] != 0) begin
        errors++;
        $display("FAIL stall_stable lat%0d got %0d want 0",
          d + 1, stall_err[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    load_directed();
    clear_mon();
    tick();
    start = 1'b1; rdy = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (beats[1].size() < 3 && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (beats[1].size() < 3) begin
      errors++;
      $display("FAIL rstmid_wait got %0d beats want 3",
        beats[1].size());
    end
    rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], done[d], vld[d], last[d], cvld[d],
           addrb[d], data[d], node[d], cidx[d],
           cnode[d]} !== '0 || done_cnt[d] != 0) begin
        errors++;
        $display("FAIL rstmid_zero lat%0d got %h done %0d want 0",
          d + 1, {busy[d], done[d], vld[d], last[d],
          cvld[d], addrb[d], data[d], node[d], cidx[d],
          cnode[d]}, done_cnt[d]);
      end
    end
    rst = 1'b0;
    build_model();
    clear_mon();
    run(0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (beats[d].size() != DEPTH || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL rstmid_rerun lat%0d got %0d/%0d want %0d/1",
          d + 1, beats[d].size(), done_cnt[d], DEPTH);
      end
      for (int i = 0; i < DEPTH && i < beats[d].size(); i++) begin
        checks++;
        if (beats[d][i] !== exp_beats[i]) begin
          errors++;
          $display("FAIL rstmid_beat%0d lat%0d got %h want %h",
            i, d + 1, beats[d][i], exp_beats[i]);
        end
      end
    end
  endtask

  task automatic test_restart();
    load_directed();
    build_model();
    clear_mon();
    run(4);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (done_cnt[d] != 1) begin
        errors++;
        $display("FAIL restart_done lat%0d got %0d want 1",
          d + 1, done_cnt[d]);
      end
      checks++;
      if (beats[d].size() != DEPTH || clss[d].size() != NS) begin
        errors++;
        $display("FAIL restart_count lat%0d got %0d/%0d want %0d/%0d",
          d + 1, beats[d].size(), clss[d].size(), DEPTH, NS);
      end
      for (int i = 0; i < DEPTH && i < beats[d].size(); i++) begin
        checks++;
        if (beats[d][i] !== exp_beats[i]) begin
          errors++;
          $display("FAIL restart_beat%0d lat%0d got %h want %h",
            i, d + 1, beats[d][i], exp_beats[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      if (it == 0) begin
        mem[1] = mem[0];
        mem[4] = mem[3];
      end
      build_model();
      clear_mon();
      run(2);
      checks++;
      if (!finished) begin
        errors++;
        $display("FAIL rand%0d_done got %0d/%0d want 1/1",
          it, done_cnt[0], done_cnt[1]);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (beats[d].size() != DEPTH || stall_err[d] != 0) begin
          errors++;
          $display("FAIL rand%0d_beats lat%0d got %0d/%0d want %0d/0",
            it, d + 1, beats[d].size(), stall_err[d], DEPTH);
        end
        for (int i = 0; i < DEPTH && i < beats[d].size(); i++) begin
          checks++;
          if (beats[d][i] !== exp_beats[i]) begin
            errors++;
            $display("FAIL rand%0d_beat%0d lat%0d got %h want %h",
              it, i, d + 1, beats[d][i], exp_beats[i]);
          end
        end
        for (int i = 0; i < NS; i++) begin
          checks++;
          if (i >= clss[d].size() || clss[d][i] !== exp_cls[i]) begin
            errors++;
            $display("FAIL rand%0d_cls%0d lat%0d got %0d entries want %h",
              it, i, d + 1, clss[d].size(), exp_cls[i]);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
